sme_feeder: RTL and testbench

Upstream record feeder for the string-matching engine (SME). It accepts framed string and pattern records over a valid/ready byte stream and buffers one record at a time. It replays each record to the SME as a gap-separated `isstring`/`ispattern` burst, and it holds off the next record after every pattern until the SME raises `valid`. This guarantees that records are never concatenated and that a pattern is never overwritten mid-search.

---
 rtl/sme_pkg.sv | 21 ++
 rtl/sme_feeder.sv | 111 +++++++++++
 tb/tb_sme_feeder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// Definitions shared between the SME and its record feeder: FSM states,
// default record limits and the pattern metacharacter codes.
package sme_pkg;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    EMIT     = 2'd1,
    GAP      = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  localparam int STR_LEN_DEF = 32;
  localparam int PAT_LEN_DEF = 8;

  localparam logic [7:0] META_CARET  = 8'h5E;
  localparam logic [7:0] META_DOLLAR = 8'h24;
  localparam logic [7:0] META_DOT    = 8'h2E;
  localparam logic [7:0] META_STAR   = 8'h2A;
  localparam logic [7:0] SPACE       = 8'h20;

endpackage

// File: rtl/sme_feeder.sv
// Buffers one framed string/pattern record and replays it to the SME as a
// gap-terminated burst, holding off new records until each pattern resolves.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_LEN = STR_LEN_DEF,
  parameter int PAT_LEN = PAT_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  // Upstream valid/ready: a byte transfers on any rising clk edge where
  // in_valid && in_ready; in_data/in_kind/in_last must be stable while
  // in_valid is high, and in_ready depends only on registered state.
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err_len,
  output logic       err_seq,
  output logic [7:0] pat_count,
  output state_t     state_dbg
);

  localparam logic [5:0] STR_LIM = 6'(STR_LEN);
  localparam logic [5:0] PAT_LIM = 6'(PAT_LEN);

  state_t     state_q, state_d;
  logic [5:0] len_q, idx_q;
  logic       kind_q, prev_string_q;
  logic       err_len_q, err_seq_q;
  logic [7:0] pat_count_q;
  logic [7:0] rec_buf [0:31];

  logic       hs;
  logic       kind_eff;
  logic [5:0] limit;
  logic       room;

  assign hs       = in_valid && (state_q == LOAD);
  // The first byte of a record carries its kind; later bytes use the latch.
  assign kind_eff = (len_q == 6'd0) ? in_kind : kind_q;
  assign limit    = kind_eff ? PAT_LIM : STR_LIM;
  assign room     = (len_q < limit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:     if (hs && in_last) state_d = EMIT;
      EMIT:     if (idx_q == len_q - 6'd1) state_d = GAP;
      GAP:      state_d = kind_q ? WAIT_RES : LOAD;
      WAIT_RES: if (sme_valid) state_d = LOAD;
      default:  state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      len_q         <= 6'd0;
      idx_q         <= 6'd0;
      kind_q        <= 1'b0;
      prev_string_q <= 1'b0;
      err_len_q     <= 1'b0;
      err_seq_q     <= 1'b0;
      pat_count_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: if (hs) begin
          if (len_q == 6'd0) kind_q <= in_kind;
          if (room) len_q <= len_q + 6'd1;
          else      err_len_q <= 1'b1;
          if (in_last) begin
            idx_q         <= 6'd0;
            if (!kind_eff && prev_string_q) err_seq_q <= 1'b1;
            prev_string_q <= !kind_eff;
          end
        end
        EMIT: idx_q <= idx_q + 6'd1;
        GAP: begin
          len_q <= 6'd0;
          idx_q <= 6'd0;
        end
        WAIT_RES: if (sme_valid) pat_count_q <= pat_count_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Record storage needs no reset: len gates every read.
  always_ff @(posedge clk) begin
    if (hs && room) rec_buf[len_q[4:0]] <= in_data;
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign chardata  = (state_q == EMIT) ? rec_buf[idx_q[4:0]] : 8'h00;
  assign isstring  = (state_q == EMIT) && !kind_q;
  assign ispattern = (state_q == EMIT) && kind_q;
  assign err_len   = err_len_q;
  assign err_seq   = err_seq_q;
  assign pat_count = pat_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: record replay, hold-off, length/sequence
// errors, mid-record reset and pattern counter wrap.
module tb_sme_feeder;
  import sme_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_kind, in_last;
  logic [7:0] in_data, chardata, pat_count;
  logic       isstring, ispattern, sme_valid, busy, err_len, err_seq;
  state_t     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] vec [0:63];

  sme_feeder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .busy(busy), .err_len(err_len), .err_seq(err_seq),
    .pat_count(pat_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_str(input string s);
    for (int i = 0; i < s.len(); i++) vec[i] = s[i];
  endtask

  // Ends at the negedge of the first EMIT cycle with in_valid dropped.
  task automatic send_rec(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vec[i];
      in_kind  = k;
      in_last  = (i == n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the first EMIT negedge; ends at the negedge after the gap.
  task automatic check_emit(input string tag, input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_isstring"}, isstring, !k);
      chk({tag, "_ispattern"}, ispattern, k);
      chk($sformatf("%s_byte%0d", tag, i), chardata, vec[i]);
      chk({tag, "_ready_emit"}, in_ready, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_gap"}, {chardata, isstring, ispattern}, 10'd0);
    chk({tag, "_gap_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_ready_after"}, in_ready, !k);
  endtask

  task automatic resolve(input logic [7:0] exp_cnt);
    sme_valid = 1'b1;
    @(negedge clk);
    sme_valid = 1'b0;
    chk("resolve_count", pat_count, exp_cnt);
    chk("resolve_ready", in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_kind = 1'b0;
    in_last = 1'b0; sme_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {chardata, isstring, ispattern}, 10'd0);
    chk("rst_errs", {err_len, err_seq}, 2'b00);
    chk("rst_count", pat_count, 8'd0);
    reset = 1'b0;

    // String "ab cd" with a stray sme_valid that must be ignored outside WAIT_RES.
    set_str("ab cd");
    sme_valid = 1'b1;
    send_rec(1'b0, 5);
    check_emit("str_abcd", 1'b0, 5);
    chk("ignore_valid_count", pat_count, 8'd0);
    sme_valid = 1'b0;

    // Pattern "cd", then three idle cycles in WAIT_RES before resolving.
    set_str("cd");
    send_rec(1'b1, 2);
    check_emit("pat_cd", 1'b1, 2);
    chk("wait_state", state_dbg, WAIT_RES);
    repeat (3) begin
      @(negedge clk);
      chk("wait_ready", in_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
    end
    resolve(8'd1);

    // Back-to-back patterns: the second is stalled until the first resolves.
    set_str("ab");
    send_rec(1'b1, 2);
    check_emit("pat_ab", 1'b1, 2);
    in_valid = 1'b1; in_data = 8'h78; in_kind = 1'b1; in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("holdoff_ready", in_ready, 1'b0);
      chk("holdoff_pattern", ispattern, 1'b0);
    end
    in_valid = 1'b0;
    resolve(8'd2);
    set_str("xy");
    send_rec(1'b1, 2);
    check_emit("pat_xy", 1'b1, 2);
    resolve(8'd3);

    // One-byte pattern "."
    vec[0] = META_DOT;
    send_rec(1'b1, 1);
    check_emit("pat_dot", 1'b1, 1);
    resolve(8'd4);

    // 10-byte pattern truncated to 8.
    chk("errlen_before", err_len, 1'b0);
    set_str("0123456789");
    send_rec(1'b1, 10);
    check_emit("pat_long", 1'b1, 8);
    chk("errlen_pat", err_len, 1'b1);
    resolve(8'd5);

    // 35-byte string truncated to 32.
    for (int i = 0; i < 35; i++) vec[i] = 8'h41 + 8'(i);
    send_rec(1'b0, 35);
    check_emit("str_long", 1'b0, 32);
    chk("errlen_str", err_len, 1'b1);
    set_str("zz");
    send_rec(1'b1, 2);
    check_emit("pat_zz", 1'b1, 2);
    resolve(8'd6);

    // String, string, pattern: second string flags err_seq yet is forwarded.
    set_str("abc");
    send_rec(1'b0, 3);
    check_emit("seq_s1", 1'b0, 3);
    chk("errseq_before", err_seq, 1'b0);
    set_str("de");
    send_rec(1'b0, 2);
    chk("errseq_set", err_seq, 1'b1);
    check_emit("seq_s2", 1'b0, 2);
    set_str("cd");
    send_rec(1'b1, 2);
    check_emit("seq_pat", 1'b1, 2);
    resolve(8'd7);

    // Reset during the 3rd EMIT cycle, then resend in full.
    set_str("hello");
    send_rec(1'b0, 5);
    repeat (2) @(negedge clk);
    chk("mid_byte3", chardata, 8'h6C);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_outs", {chardata, isstring, ispattern}, 10'd0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_count", pat_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_errs", {err_len, err_seq}, 2'b00);
    send_rec(1'b0, 5);
    check_emit("resend", 1'b0, 5);

    // 256 resolved patterns wrap the counter.
    vec[0] = META_DOT;
    for (int n = 1; n <= 256; n++) begin
      send_rec(1'b1, 1);
      repeat (2) @(negedge clk);
      sme_valid = 1'b1;
      @(negedge clk);
      sme_valid = 1'b0;
      if (n == 255) chk("count_255", pat_count, 8'd255);
    end
    chk("count_wrap", pat_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
